// File: rtl/vga_timing_pkg.sv
// Shared types, default 800x600@72 timing and sizing helpers for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BACK    = 64;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BACK    = 23;
  localparam int DEF_H_POL     = 1;
  localparam int DEF_V_POL     = 1;
  localparam int DEF_LOOKAHEAD = 2;

  function automatic int seg_total(input int visible, input int front,
                                   input int sync_len, input int back);
    return visible + front + sync_len + back;
  endfunction

  // One shared coordinate width so X and Y ports have the same type.
  function automatic int axis_width(input int h_total, input int v_total);
    return $clog2((h_total > v_total) ? h_total : v_total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, end-of-axis wrap flag and ACTIVE/FRONT/SYNC/BACK region FSM.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS_LEN   = DEF_H_VISIBLE,
  parameter int FRONT_LEN = DEF_H_FRONT,
  parameter int SYNC_LEN  = DEF_H_SYNC,
  parameter int BACK_LEN  = DEF_H_BACK,
  parameter int W         = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output region_t      region
);

  localparam int TOTAL = seg_total(VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
  localparam logic [W-1:0] FRONT_AT = W'(VIS_LEN);
  localparam logic [W-1:0] SYNC_AT  = W'(VIS_LEN + FRONT_LEN);
  localparam logic [W-1:0] BACK_AT  = W'(VIS_LEN + FRONT_LEN + SYNC_LEN);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

  region_t      region_next;
  logic [W-1:0] count_next;

  assign wrap       = (count == LAST);
  assign count_next = wrap ? '0 : count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      region <= ACTIVE;
    end else begin
      region <= region_next;
      if (step) count <= count_next;
    end
  end

  // Region follows the value the counter is about to take, so it always matches count.
  always_comb begin
    region_next = region;
    if (step) begin
      case (region)
        ACTIVE:  if (count_next == FRONT_AT) region_next = FRONT;
        FRONT:   if (count_next == SYNC_AT)  region_next = SYNC;
        SYNC:    if (count_next == BACK_AT)  region_next = BACK;
        BACK:    if (wrap)                   region_next = ACTIVE;
        default: region_next = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable and sync polarity.
// Optional prefetch outputs Req/Req_X/Req_Y are built when VGA_TIMING_LOOKAHEAD_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int H_POL     = DEF_H_POL,
  parameter int V_POL     = DEF_V_POL,
  parameter int LOOKAHEAD = DEF_LOOKAHEAD,
  localparam int H_TOTAL  = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL  = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int CW       = axis_width(H_TOTAL, V_TOTAL)
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          Pix_En,
  output logic          H_Sync,
  output logic          V_Sync,
  output logic          Active_Zone,
  output logic [CW-1:0] X_pos,
  output logic [CW-1:0] Y_pos,
  output logic          Line_Start,
  output logic          Frame_Start,
  output logic [7:0]    Frame_Count
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic          Req,
  output logic [CW-1:0] Req_X,
  output logic [CW-1:0] Req_Y
`endif
);

  localparam logic H_ON = 1'(H_POL);
  localparam logic V_ON = 1'(V_POL);

  if (LOOKAHEAD < 1 || LOOKAHEAD > H_BACK) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must lie in 1..H_BACK");
  end

  logic [CW-1:0] h_count, v_count;
  logic          h_wrap, v_wrap, v_step, visible;
  region_t       h_region, v_region;
  logic [7:0]    frame_cnt;

  assign v_step  = Pix_En & h_wrap;
  assign visible = (h_region == ACTIVE) && (v_region == ACTIVE);

  vga_axis_counter #(
    .VIS_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .W(CW)
  ) u_h_axis (
    .clk(CLOCK), .reset(RESET), .step(Pix_En),
    .count(h_count), .wrap(h_wrap), .region(h_region)
  );

  vga_axis_counter #(
    .VIS_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .W(CW)
  ) u_v_axis (
    .clk(CLOCK), .reset(RESET), .step(v_step),
    .count(v_count), .wrap(v_wrap), .region(v_region)
  );

  // Counts frames completed; the registered copy lands alongside the next Frame_Start.
  always_ff @(posedge CLOCK) begin
    if (RESET)                frame_cnt <= '0;
    else if (v_step & v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      H_Sync      <= ~H_ON;
      V_Sync      <= ~V_ON;
      Active_Zone <= 1'b0;
      X_pos       <= '0;
      Y_pos       <= '0;
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_Count <= '0;
    end else if (Pix_En) begin
      H_Sync      <= (h_region == SYNC) ? H_ON : ~H_ON;
      V_Sync      <= (v_region == SYNC) ? V_ON : ~V_ON;
      Active_Zone <= visible;
      X_pos       <= visible ? h_count : '0;
      Y_pos       <= visible ? v_count : '0;
      Line_Start  <= (h_count == '0);
      Frame_Start <= (h_count == '0) && (v_count == '0);
      Frame_Count <= frame_cnt;
    end else begin
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [CW:0]   h_sum;
  logic          h_over, req_visible;
  logic [CW-1:0] h_ahead, v_ahead;

  // LOOKAHEAD never exceeds H_BACK, so the lead position crosses at most one line boundary.
  always_comb begin
    h_sum   = {1'b0, h_count} + (CW+1)'(LOOKAHEAD);
    h_over  = (h_sum >= (CW+1)'(H_TOTAL));
    h_ahead = h_over ? CW'(h_sum - (CW+1)'(H_TOTAL)) : h_sum[CW-1:0];
    v_ahead = v_count;
    if (h_over) v_ahead = v_wrap ? '0 : v_count + 1'b1;
    req_visible = (h_ahead < CW'(H_VISIBLE)) && (v_ahead < CW'(V_VISIBLE));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      Req   <= 1'b0;
      Req_X <= '0;
      Req_Y <= '0;
    end else if (Pix_En) begin
      Req   <= req_visible;
      Req_X <= req_visible ? h_ahead : '0;
      Req_Y <= req_visible ? v_ahead : '0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a 14x7 small mode with low-active syncs and the default 800x600@72 mode.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs, vs, act, ls, fs;
    logic [10:0] x, y;
    logic [7:0]  fc;
    logic        req;
    logic [10:0] rx, ry;
  } exp_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, hpol, vpol, la;
  } mode_t;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic       rst_s, en_s, hs_s, vs_s, act_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;
  logic [7:0] fc_s;
  logic        rst_d, en_d, hs_d, vs_d, act_d, ls_d, fs_d;
  logic [10:0] x_d, y_d;
  logic [7:0]  fc_d;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic        req_s, req_d;
  logic [3:0]  rx_s, ry_s;
  logic [10:0] rx_d, ry_d;
`endif

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0), .LOOKAHEAD(2)
  ) dut_s (
    .CLOCK(CLOCK), .RESET(rst_s), .Pix_En(en_s),
    .H_Sync(hs_s), .V_Sync(vs_s), .Active_Zone(act_s),
    .X_pos(x_s), .Y_pos(y_s), .Line_Start(ls_s), .Frame_Start(fs_s),
    .Frame_Count(fc_s)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .Req(req_s), .Req_X(rx_s), .Req_Y(ry_s)
`endif
  );

  vga_timing_gen dut_d (
    .CLOCK(CLOCK), .RESET(rst_d), .Pix_En(en_d),
    .H_Sync(hs_d), .V_Sync(vs_d), .Active_Zone(act_d),
    .X_pos(x_d), .Y_pos(y_d), .Line_Start(ls_d), .Frame_Start(fs_d),
    .Frame_Count(fc_d)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .Req(req_d), .Req_X(rx_d), .Req_Y(ry_d)
`endif
  );

  int    nCompared = 0;
  int    nMismatched = 0;
  mode_t md[2];
  int    mh[2], mv[2], mf[2];
  exp_t  eo[2];
  exp_t  qS[$];
  exp_t  qD[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t resetExp(input mode_t p);
    exp_t e;
    e = '0;
    e.hs = (p.hpol == 0);
    e.vs = (p.vpol == 0);
    return e;
  endfunction

  function automatic exp_t calcExpected(input mode_t p, input int h, input int v, input int f);
    exp_t e;
    int ht, vt, ha, va;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    e = '0;
    e.act = (h < p.hv) && (v < p.vv);
    e.hs = (h >= p.hv + p.hf && h < p.hv + p.hf + p.hs) ? (p.hpol != 0) : (p.hpol == 0);
    e.vs = (v >= p.vv + p.vf && v < p.vv + p.vf + p.vs) ? (p.vpol != 0) : (p.vpol == 0);
    e.x = e.act ? 11'(h) : 11'd0;
    e.y = e.act ? 11'(v) : 11'd0;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.fc = 8'(f);
    ha = h + p.la;
    va = v;
    if (ha >= ht) begin
      ha = ha - ht;
      va = (v + 1) % vt;
    end
    e.req = (ha < p.hv) && (va < p.vv);
    e.rx = e.req ? 11'(ha) : 11'd0;
    e.ry = e.req ? 11'(va) : 11'd0;
    return e;
  endfunction

  function automatic exp_t sampleDut(input int d);
    exp_t g;
    g = '0;
    if (d == 0) begin
      g.hs = hs_s; g.vs = vs_s; g.act = act_s; g.ls = ls_s; g.fs = fs_s;
      g.x = 11'(x_s); g.y = 11'(y_s); g.fc = fc_s;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      g.req = req_s; g.rx = 11'(rx_s); g.ry = 11'(ry_s);
`endif
    end else begin
      g.hs = hs_d; g.vs = vs_d; g.act = act_d; g.ls = ls_d; g.fs = fs_d;
      g.x = x_d; g.y = y_d; g.fc = fc_d;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      g.req = req_d; g.rx = rx_d; g.ry = ry_d;
`endif
    end
    return g;
  endfunction

  task automatic compareDut(input int d);
    exp_t e, g;
    if ((d == 0 && qS.size() == 0) || (d == 1 && qD.size() == 0)) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = (d == 0) ? qS.pop_front() : qD.pop_front();
    g = sampleDut(d);
    checkOutput("sync", 32'({g.hs, g.vs}), 32'({e.hs, e.vs}));
    checkOutput("active", 32'(g.act), 32'(e.act));
    checkOutput("xy", 32'({g.x, g.y}), 32'({e.x, e.y}));
    checkOutput("strobes", 32'({g.ls, g.fs}), 32'({e.ls, e.fs}));
    checkOutput("fcount", 32'(g.fc), 32'(e.fc));
`ifdef VGA_TIMING_LOOKAHEAD_EN
    checkOutput("req", 32'(g.req), 32'(e.req));
    checkOutput("req_xy", 32'({g.rx, g.ry}), 32'({e.rx, e.ry}));
`endif
  endtask

  // Drives one clock of stimulus to DUT d (the other DUT is parked in reset) and scores the result.
  task automatic applyStimulus(input int d, input bit en, input bit rst);
    int ht, vt;
    @(negedge CLOCK);
    if (d == 0) begin
      en_s = en; rst_s = rst; en_d = 1'b0; rst_d = 1'b1;
    end else begin
      en_d = en; rst_d = rst; en_s = 1'b0; rst_s = 1'b1;
    end
    ht = md[d].hv + md[d].hf + md[d].hs + md[d].hb;
    vt = md[d].vv + md[d].vf + md[d].vs + md[d].vb;
    if (rst) begin
      eo[d] = resetExp(md[d]);
      mh[d] = 0; mv[d] = 0; mf[d] = 0;
    end else if (en) begin
      eo[d] = calcExpected(md[d], mh[d], mv[d], mf[d]);
      if (mh[d] == ht - 1) begin
        mh[d] = 0;
        if (mv[d] == vt - 1) begin
          mv[d] = 0;
          mf[d] = (mf[d] + 1) % 256;
        end else mv[d]++;
      end else mh[d]++;
    end else begin
      eo[d].ls = 1'b0;
      eo[d].fs = 1'b0;
    end
    if (d == 0) qS.push_back(eo[d]);
    else        qD.push_back(eo[d]);
    @(posedge CLOCK);
    #1;
    compareDut(d);
  endtask

  initial begin
    int lastLs, linePeriod, fsSeen, guard;
    int fcAtFs[3];
    int hsOn, actOn, lsFirst, lsPeriod;

    md[0] = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 2};
    md[1] = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 2};
    rst_s = 1'b1; en_s = 1'b0; rst_d = 1'b1; en_d = 1'b0;

    repeat (2) applyStimulus(0, 1'b1, 1'b1);

    lastLs = -1; linePeriod = 0; fsSeen = 0;
    for (int i = 0; i < 420; i++) begin
      applyStimulus(0, (i % 2) == 0, 1'b0);
      if (ls_s) begin
        if (lastLs >= 0 && linePeriod == 0) linePeriod = i - lastLs;
        lastLs = i;
      end
      if (fs_s && fsSeen < 3) begin
        fcAtFs[fsSeen] = int'(fc_s);
        fsSeen++;
      end
    end
    checkOutput("line_clocks", 32'(linePeriod), 32'd28);
    checkOutput("frame_starts", 32'(fsSeen), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < fsSeen) checkOutput("fc_at_fs", 32'(fcAtFs[k]), 32'(k));

    for (int i = 0; i < 60; i++) applyStimulus(0, 1'($urandom_range(0, 1)), 1'b0);

    applyStimulus(0, 1'b1, 1'b1);
    guard = 0;
    while (!(mh[0] == 5 && mv[0] == 2) && guard < 500) begin
      applyStimulus(0, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("rst_active", 32'(act_s), 32'd0);
    checkOutput("rst_hsync", 32'(hs_s), 32'd1);
    checkOutput("rst_fcount", 32'(fc_s), 32'd0);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("post_rst_fs", 32'(fs_s), 32'd1);
    checkOutput("post_rst_xy", 32'({x_s, y_s}), 32'd0);
    repeat (30) applyStimulus(0, 1'b1, 1'b0);

    applyStimulus(1, 1'b1, 1'b1);
    hsOn = 0; actOn = 0; lsFirst = -1; lsPeriod = 0;
    for (int i = 1; i <= 1042; i++) begin
      applyStimulus(1, 1'b1, 1'b0);
      if (i <= 1040) begin
        if (hs_d)  hsOn++;
        if (act_d) actOn++;
      end
      if (ls_d) begin
        if (lsFirst < 0) lsFirst = i;
        else if (lsPeriod == 0) lsPeriod = i - lsFirst;
      end
    end
    checkOutput("hsync_width", 32'(hsOn), 32'd120);
    checkOutput("active_width", 32'(actOn), 32'd800);
    checkOutput("line_period", 32'(lsPeriod), 32'd1040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
